trace_checker: RTL and testbench
================================

# trace_checker

- Parametrised hardware self-checker for processor bring-up.
- Holds a table of expected per-step vectors: instruction word, ALU operand A, ALU operand B, or any CHANNELS signals.
- Compares each strobed processor step against the next table entry and counts per-channel mismatches.
- Sits beside `skeleton`, sampling its observation buses on the processor step, so regression runs on silicon or in simulation without a behavioural bench task.

## Interface

Parameters:
- WIDTH, 32, bits per channel
- CHANNELS, 3, observed channels per step
- DEPTH, 64, table entries (power of two); AW = $clog2(DEPTH)
- ERR_W, 16, error counter width

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  synchronous, active-high
- load_en  in  1  write table entry
- load_addr  in  AW  entry index
- load_data  in  CHANNELS*WIDTH  expected values, channel 0 in LSBs
- load_mask  in  CHANNELS  per-channel compare enable (0 = don't care)
- start  in  1  begin run, one-cycle pulse
- length  in  AW+1  entries to check this run
- sample_valid  in  1  one processor step observed
- sample_data  in  CHANNELS*WIDTH  observed values, same packing
- busy  out  1  in RUN
- done  out  1  run finished, level
- pass  out  1  done and err_count == 0
- mismatch  out  CHANNELS  per-channel fail flags of last sample, one-cycle pulse
- err_count  out  ERR_W  total mismatching channels, saturating
- index  out  AW+1  samples consumed this run
- first_fail_valid  out  1  a failure has been captured
- first_fail_index  out  AW+1  entry index of first failure
- first_fail_chan  out  CHANNELS  mismatch mask of first failing entry

## Operation

States:
- IDLE: table writable. start → RUN; latch length, clamped to DEPTH. Clear index, err_count, mismatch, done, first_fail_*.
- RUN: on each sample_valid, compare sample_data to entry[index]. Per channel, a mismatch is (observed !== expected) & mask bit. Increment index.
  - When index reaches the latched length → DONE.
  - start ignored; load_en ignored (table frozen).
- DONE: done=1. Outputs hold. start → RUN with the same clears as IDLE. load_en accepted.

Counting and capture:
- err_count += popcount(mismatch flags), saturating at 2^ERR_W−1; never wraps.
- Entry with load_mask = 0 is a skip step (jump/branch bubble): consumes a sample, never fails.
- length = 0: start → DONE on the next edge; pass=1.
- sample_valid outside RUN is ignored.

Reset:
- Reset value of all outputs: busy, done, pass, mismatch, err_count, index, first_fail_* = 0; state IDLE.
- Reset mid-run aborts the run; no done.
- Table contents are not reset; they retain prior writes and are undefined after power-up.

## Timing

- Table read is asynchronous from a register array; compare is combinational; results are registered.
- Sample at edge N → mismatch, err_count, index, and first_fail_* valid after edge N, i.e. 1-cycle latency.
- The last sample at edge N: busy falls and done/pass rise after edge N, same cycle as the final err_count.
- Back-to-back sample_valid every cycle is supported at full rate.
- load_en and start in the same cycle from IDLE/DONE: the write completes and the run starts; the written entry is visible to the first sample.

## Configuration

- Macro: TRACE_CHECKER_CAPTURE_EN.
- Defined: first_fail_valid/index/chan capture the first failing sample of the run and hold until the next start or reset.
- Undefined: capture logic is omitted; first_fail_* are tied to 0; all other behaviour is identical.

## Test plan

- Load 4 entries {0x28400005,0,5}, {0x28800003,0,3}, {0x00C22000,5,3}, {0x28C60000,8,0}, all masks 0b111; length=4; feed identical samples on consecutive cycles → done=1, pass=1, err_count=0, index=4, busy low the cycle after the 4th sample.
- Same table, sample 3 channel 1 = 6 instead of 5 → mismatch=0b010 one cycle only, err_count=1, first_fail_index=2, first_fail_chan=0b010, pass=0.
- Entry 1 mask=0; sample 1 = all-ones garbage → no mismatch, err_count=0; skip step consumed (index advances).
- ERR_W=2; 2 entries masks 0b111; both samples wrong on all channels → err_count saturates at 3, not wrap.
- length=0 start → done next cycle, pass=1. Separately, reset asserted after 2 of 4 samples → all outputs 0, IDLE. Restart with length=4 checks entries 0–3 from index 0.
- Build without TRACE_CHECKER_CAPTURE_EN, repeat the failing scenario → err_count=1, first_fail_* all 0.

Source files
------------

// File: rtl/trace_checker_if.sv
// Bus bundle for trace_checker: table load, run control, sample strobe and result outputs.
// master drives the table/run/sample side, slave is the checker itself.
interface trace_checker_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned ERR_W    = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                      load_en;
    logic [AW-1:0]             load_addr;
    logic [CHANNELS*WIDTH-1:0] load_data;
    logic [CHANNELS-1:0]       load_mask;
    logic                      start;
    logic [AW:0]               length;
    logic                      sample_valid;
    logic [CHANNELS*WIDTH-1:0] sample_data;

    logic                      busy;
    logic                      done;
    logic                      pass;
    logic [CHANNELS-1:0]       mismatch;
    logic [ERR_W-1:0]          err_count;
    logic [AW:0]               index;
    logic                      first_fail_valid;
    logic [AW:0]               first_fail_index;
    logic [CHANNELS-1:0]       first_fail_chan;

    modport master (
        output load_en, load_addr, load_data, load_mask, start, length,
        output sample_valid, sample_data,
        input  busy, done, pass, mismatch, err_count, index,
        input  first_fail_valid, first_fail_index, first_fail_chan
    );

    modport slave (
        input  load_en, load_addr, load_data, load_mask, start, length,
        input  sample_valid, sample_data,
        output busy, done, pass, mismatch, err_count, index,
        output first_fail_valid, first_fail_index, first_fail_chan
    );
endinterface

// File: rtl/trace_checker.sv
// Compares strobed processor steps against a preloaded table of expected vectors.
// First-failure capture is built only when TRACE_CHECKER_CAPTURE_EN is defined.
module trace_checker #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned ERR_W    = 16
) (
    input logic            clock,
    input logic            reset,
    trace_checker_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(CHANNELS + 1);
    localparam int unsigned SW = ERR_W + PW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [AW:0]         len_q, len_d;
    logic [AW:0]         index_q, index_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [CHANNELS-1:0] mismatch_q, mismatch_d;

    logic [CHANNELS*WIDTH-1:0] table_data [DEPTH];
    logic [CHANNELS-1:0]       table_mask [DEPTH];

    logic [CHANNELS*WIDTH-1:0] exp_data;
    logic [CHANNELS-1:0]       exp_mask;
    logic [CHANNELS-1:0]       cmp_vec;
    logic [PW-1:0]             cmp_pop;
    logic [SW-1:0]             err_sum;
    logic [ERR_W-1:0]          err_sat;
    logic [AW:0]               len_clamped;
    logic                      accept;
    logic                      launch;
    logic                      table_wr;

    assign accept   = (state_q == ST_RUN) && bus.sample_valid;
    assign launch   = (state_q != ST_RUN) && bus.start;
    assign table_wr = (state_q != ST_RUN) && bus.load_en;

    assign len_clamped = (bus.length > (AW + 1)'(DEPTH)) ? (AW + 1)'(DEPTH) : bus.length;

    // Table is frozen while a run is in progress.
    always_ff @(posedge clock) begin
        if (table_wr) begin
            table_data[bus.load_addr] <= bus.load_data;
            table_mask[bus.load_addr] <= bus.load_mask;
        end
    end

    assign exp_data = table_data[index_q[AW-1:0]];
    assign exp_mask = table_mask[index_q[AW-1:0]];

    always_comb begin
        cmp_vec = '0;
        cmp_pop = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cmp_vec[c] = exp_mask[c] &&
                (bus.sample_data[c*WIDTH +: WIDTH] !== exp_data[c*WIDTH +: WIDTH]);
            cmp_pop = cmp_pop + PW'(cmp_vec[c]);
        end
    end

    always_comb begin
        err_sum = SW'(err_q) + SW'(cmp_pop);
        err_sat = (|err_sum[SW-1:ERR_W]) ? '1 : err_sum[ERR_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        index_d    = index_q;
        err_d      = err_q;
        mismatch_d = '0;
        if (launch) begin
            len_d   = len_clamped;
            index_d = '0;
            err_d   = '0;
            state_d = (len_clamped == '0) ? ST_DONE : ST_RUN;
        end else if (accept) begin
            mismatch_d = cmp_vec;
            err_d      = err_sat;
            index_d    = index_q + 1'b1;
            if (index_d == len_q) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            index_q    <= '0;
            err_q      <= '0;
            mismatch_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            index_q    <= index_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = (state_q == ST_DONE) && (err_q == '0);
    assign bus.mismatch  = mismatch_q;
    assign bus.err_count = err_q;
    assign bus.index     = index_q;

`ifdef TRACE_CHECKER_CAPTURE_EN
    logic                ff_valid_q;
    logic [AW:0]         ff_index_q;
    logic [CHANNELS-1:0] ff_chan_q;

    always_ff @(posedge clock) begin
        if (reset || launch) begin
            ff_valid_q <= 1'b0;
            ff_index_q <= '0;
            ff_chan_q  <= '0;
        end else if (accept && (|cmp_vec) && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_index_q <= index_q;
            ff_chan_q  <= cmp_vec;
        end
    end

    assign bus.first_fail_valid = ff_valid_q;
    assign bus.first_fail_index = ff_index_q;
    assign bus.first_fail_chan  = ff_chan_q;
`else
    assign bus.first_fail_valid = 1'b0;
    assign bus.first_fail_index = '0;
    assign bus.first_fail_chan  = '0;
`endif
endmodule

// File: tb/tb_trace_checker.sv
// Randomised bench for trace_checker: a second instance with ERR_W=2 shares the stimulus so
// counter saturation is checked on every step alongside the full-width counter.
module tb_trace_checker;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned CHANNELS = 3;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned AW       = 6;
    localparam int unsigned DW       = CHANNELS * WIDTH;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    trace_checker_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ERR_W(16)) bus_a ();
    trace_checker_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ERR_W(2)) bus_s ();

    assign bus_s.load_en      = bus_a.load_en;
    assign bus_s.load_addr    = bus_a.load_addr;
    assign bus_s.load_data    = bus_a.load_data;
    assign bus_s.load_mask    = bus_a.load_mask;
    assign bus_s.start        = bus_a.start;
    assign bus_s.length       = bus_a.length;
    assign bus_s.sample_valid = bus_a.sample_valid;
    assign bus_s.sample_data  = bus_a.sample_data;

    trace_checker #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ERR_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    trace_checker #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ERR_W(2)) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s)
    );

    // Reference model: expected table, observation plan and run bookkeeping.
    logic [DW-1:0]       m_data [DEPTH];
    logic [CHANNELS-1:0] m_mask [DEPTH];
    logic [DW-1:0]       obs    [DEPTH];
    int                  m_len, m_index, m_err;
    bit                  m_busy, m_done, m_ffv;
    int                  m_ffi;
    logic [CHANNELS-1:0] m_ffc;
    int                  n_tests = 0;
    int                  n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        m_len   = 0;
        m_index = 0;
        m_err   = 0;
        m_busy  = 0;
        m_done  = 0;
        m_ffv   = 0;
        m_ffi   = 0;
        m_ffc   = '0;
    endtask

    task automatic check_all(input string tag, input logic [CHANNELS-1:0] exp_mm);
        int  full;
        int  sat;
        bit  pass_exp;
        full     = (m_err > 65535) ? 65535 : m_err;
        sat      = (m_err > 3) ? 3 : m_err;
        pass_exp = m_done && (m_err == 0);
        check({tag, " busy"}, 64'(bus_a.busy), 64'(m_busy));
        check({tag, " done"}, 64'(bus_a.done), 64'(m_done));
        check({tag, " pass"}, 64'(bus_a.pass), 64'(pass_exp));
        check({tag, " mismatch"}, 64'(bus_a.mismatch), 64'(exp_mm));
        check({tag, " err_count"}, 64'(bus_a.err_count), 64'(full));
        check({tag, " index"}, 64'(bus_a.index), 64'(m_index));
        check({tag, " sat err_count"}, 64'(bus_s.err_count), 64'(sat));
        check({tag, " sat pass"}, 64'(bus_s.pass), 64'(pass_exp));
`ifdef TRACE_CHECKER_CAPTURE_EN
        check({tag, " ff_valid"}, 64'(bus_a.first_fail_valid), 64'(m_ffv));
        check({tag, " ff_index"}, 64'(bus_a.first_fail_index), 64'(m_ffi));
        check({tag, " ff_chan"}, 64'(bus_a.first_fail_chan), 64'(m_ffc));
`else
        check({tag, " ff_valid"}, 64'(bus_a.first_fail_valid), 64'd0);
        check({tag, " ff_index"}, 64'(bus_a.first_fail_index), 64'd0);
        check({tag, " ff_chan"}, 64'(bus_a.first_fail_chan), 64'd0);
`endif
    endtask

    task automatic load_entry(input int addr, input logic [DW-1:0] data,
                              input logic [CHANNELS-1:0] mask);
        bus_a.load_en   = 1'b1;
        bus_a.load_addr = AW'(addr);
        bus_a.load_data = data;
        bus_a.load_mask = mask;
        tick();
        bus_a.load_en = 1'b0;
        m_data[addr]  = data;
        m_mask[addr]  = mask;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int c = 0; c < CHANNELS; c++) w[c*WIDTH +: WIDTH] = $urandom;
        return w;
    endfunction

    task automatic start_run(input int len, input bit with_load0);
        bus_a.start  = 1'b1;
        bus_a.length = (AW + 1)'(len);
        if (with_load0) begin
            bus_a.load_en   = 1'b1;
            bus_a.load_addr = '0;
            bus_a.load_data = rand_word();
            bus_a.load_mask = CHANNELS'($urandom);
            m_data[0] = bus_a.load_data;
            m_mask[0] = bus_a.load_mask;
            obs[0]    = bus_a.load_data;
        end
        tick();
        bus_a.start   = 1'b0;
        bus_a.load_en = 1'b0;
        model_clear();
        m_len  = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        m_done = (m_len == 0);
        m_busy = (m_len != 0);
        check_all("start", '0);
    endtask

    // Feed n samples from obs[]; gap cycles and ignored start/load pulses exercise RUN rules.
    task automatic feed(input int n, input int gap_pct, input bit chaos);
        logic [CHANNELS-1:0] exp_mm;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                bus_a.sample_valid = 1'b0;
                bus_a.sample_data  = rand_word();
                tick();
                check_all("gap", '0);
            end
            bus_a.sample_valid = 1'b1;
            bus_a.sample_data  = obs[m_index];
            if (chaos) begin
                bus_a.start     = ($urandom_range(0, 3) == 0);
                bus_a.length    = '0;
                bus_a.load_en   = ($urandom_range(0, 1) == 0);
                bus_a.load_addr = AW'($urandom);
                bus_a.load_data = rand_word();
                bus_a.load_mask = '1;
            end
            tick();
            bus_a.sample_valid = 1'b0;
            bus_a.start        = 1'b0;
            bus_a.load_en      = 1'b0;
            exp_mm = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (m_mask[m_index][c] &&
                    (obs[m_index][c*WIDTH +: WIDTH] != m_data[m_index][c*WIDTH +: WIDTH]))
                    exp_mm[c] = 1'b1;
            end
            m_err += $countones(exp_mm);
            if (exp_mm != '0 && !m_ffv) begin
                m_ffv = 1;
                m_ffi = m_index;
                m_ffc = exp_mm;
            end
            m_index++;
            if (m_index == m_len) begin
                m_busy = 0;
                m_done = 1;
            end
            check_all("step", exp_mm);
        end
        tick();
        check_all("settle", '0);
    endtask

    task automatic gen_obs(input int pct);
        for (int i = 0; i < int'(DEPTH); i++) begin
            obs[i] = m_data[i];
            for (int c = 0; c < CHANNELS; c++)
                if ($urandom_range(0, 99) < pct)
                    obs[i][c*WIDTH +: WIDTH] ^= (32'h1 << $urandom_range(0, 31));
        end
    endtask

    task automatic load_plan_table();
        load_entry(0, {32'd5, 32'd0, 32'h28400005}, 3'b111);
        load_entry(1, {32'd3, 32'd0, 32'h28800003}, 3'b111);
        load_entry(2, {32'd3, 32'd5, 32'h00C22000}, 3'b111);
        load_entry(3, {32'd0, 32'd8, 32'h28C60000}, 3'b111);
        for (int i = 0; i < 4; i++) obs[i] = m_data[i];
    endtask

    initial begin
        int len;
        bus_a.load_en      = 1'b0;
        bus_a.load_addr    = '0;
        bus_a.load_data    = '0;
        bus_a.load_mask    = '0;
        bus_a.start        = 1'b0;
        bus_a.length       = '0;
        bus_a.sample_valid = 1'b0;
        bus_a.sample_data  = '0;
        model_clear();
        reset = 1'b1;
        tick();
        tick();
        check_all("reset", '0);
        reset = 1'b0;

        // Clean run over the bring-up program.
        load_plan_table();
        start_run(4, 0);
        feed(4, 0, 0);

        // Channel 1 of the third sample wrong.
        obs[2][WIDTH +: WIDTH] = 32'd6;
        start_run(4, 0);
        feed(4, 0, 0);

        // Skip step: masked entry accepts garbage.
        load_plan_table();
        load_entry(1, m_data[1], 3'b000);
        obs[1] = '1;
        start_run(4, 0);
        feed(4, 0, 0);

        // All channels wrong on two entries: narrow counter saturates.
        load_entry(0, m_data[0], 3'b111);
        load_entry(1, m_data[1], 3'b111);
        obs[0] = ~m_data[0];
        obs[1] = ~m_data[1];
        start_run(2, 0);
        feed(2, 0, 0);

        // Zero-length run.
        start_run(0, 0);
        tick();
        check_all("len0 hold", '0);

        // Reset mid-run, ignored idle samples, then a clean restart.
        load_plan_table();
        start_run(4, 0);
        feed(2, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        check_all("midrun reset", '0);
        bus_a.sample_valid = 1'b1;
        bus_a.sample_data  = rand_word();
        tick();
        bus_a.sample_valid = 1'b0;
        check_all("idle sample", '0);
        start_run(4, 0);
        feed(4, 0, 0);

        // Randomised runs over a full random table.
        for (int i = 0; i < int'(DEPTH); i++)
            load_entry(i, rand_word(), ($urandom_range(0, 7) == 0) ? '0 : CHANNELS'($urandom));
        for (int r = 0; r < 12; r++) begin
            case (r % 4)
                0:       len = int'(DEPTH) + $urandom_range(0, 63);
                1:       len = $urandom_range(1, 4);
                default: len = $urandom_range(1, int'(DEPTH));
            endcase
            gen_obs((r % 3 == 0) ? 0 : $urandom_range(2, 40));
            start_run(len, (r % 2) == 1);
            feed((len > int'(DEPTH)) ? int'(DEPTH) : len, $urandom_range(0, 30), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
